// File: rtl/asm_pkg.sv
// Shared sizing helpers for the ASM operand-B pre-computation pipeline.
// Imported by the interface, the multiple generator and the top.
package asm_pkg;

    localparam int unsigned DEF_WIDTH     = 32;
    localparam int unsigned DEF_ALPHABETS = 4;

    // Bit n set means ALPHABETS == n is a supported configuration (2, 4, 8).
    localparam logic [8:0] LEGAL_ALPHABETS_MASK = 9'b1_0001_0100;

    function automatic int unsigned ext_bits(input int unsigned alphabets);
        return $clog2(2 * alphabets);
    endfunction

    function automatic int unsigned slot_width(input int unsigned width, input int unsigned ext);
        return width + ext;
    endfunction

    function automatic int unsigned slot_offset(input int unsigned slot, input int unsigned slot_w);
        return slot * slot_w;
    endfunction

    function automatic bit is_legal_alphabets(input int unsigned alphabets);
        logic [3:0] idx;
        idx = alphabets[3:0];
        return (alphabets <= 8) && LEGAL_ALPHABETS_MASK[idx];
    endfunction

endpackage

// File: rtl/asm_b_precomp_pipe_if.sv
// B-operand offer channel and multiple-set delivery channel of the pre-computation pipe.
// master drives B and consumes sets; slave is the pipeline itself.
interface asm_b_precomp_pipe_if
    import asm_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned ALPHABETS = DEF_ALPHABETS,
    parameter int unsigned EXT       = ext_bits(ALPHABETS),
    parameter int unsigned NIBBLES   = WIDTH / 4
);
    localparam int unsigned SW    = slot_width(WIDTH, EXT);
    localparam int unsigned NIB_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    logic                    b_valid;
    logic                    b_ready;
    logic [WIDTH-1:0]        B;
    logic                    approx_en;
    logic                    m_valid;
    logic                    m_ready;
    logic [ALPHABETS*SW-1:0] mult;
    logic [NIB_W-1:0]        nib_idx;
    logic                    last;

    modport master (
        output b_valid, B, approx_en, m_ready,
        input  b_ready, m_valid, mult, nib_idx, last
    );

    modport slave (
        input  b_valid, B, approx_en, m_ready,
        output b_ready, m_valid, mult, nib_idx, last
    );

endinterface

// File: rtl/asm_odd_multiple_gen.sv
// Combinational K*B from pre-shifted copies of B, with optional low-bit truncation.
// Copy s of i_shifted is B<<s, zero-extended to the slot width.
module asm_odd_multiple_gen
    import asm_pkg::*;
#(
    parameter int unsigned WIDTH       = DEF_WIDTH,
    parameter int unsigned EXT         = ext_bits(DEF_ALPHABETS),
    parameter int unsigned K           = 1,
    parameter int unsigned APPROX_BITS = 0
) (
    input  logic [EXT*(WIDTH+EXT)-1:0] i_shifted,
    input  logic                       i_approx,
    output logic [WIDTH+EXT-1:0]       o_mult
);
    localparam int unsigned    SW       = slot_width(WIDTH, EXT);
    localparam logic [EXT-1:0] K_BITS   = EXT'(K);
    localparam logic [SW-1:0]  LOW_MASK = SW'((64'd1 << APPROX_BITS) - 64'd1);

    logic [SW-1:0] w_term [EXT];
    logic [SW-1:0] w_sum;

    for (genvar s = 0; s < EXT; s++) begin : g_term
        assign w_term[s] = K_BITS[s] ? i_shifted[s*SW +: SW] : '0;
    end

    always_comb begin
        w_sum = '0;
        for (int unsigned s = 0; s < EXT; s++) begin
            w_sum = w_sum + w_term[s];
        end
    end

    assign o_mult = i_approx ? (w_sum & ~LOW_MASK) : w_sum;

endmodule

// File: rtl/asm_b_precomp_pipe.sv
// Two-stage operand-B pre-computation: S1 registers shifted copies of B, S2 holds the
// odd-multiple set and replays it once per A nibble before retiring it.
module asm_b_precomp_pipe
    import asm_pkg::*;
#(
    parameter int unsigned WIDTH       = DEF_WIDTH,
    parameter int unsigned ALPHABETS   = DEF_ALPHABETS,
    parameter int unsigned EXT         = ext_bits(ALPHABETS),
    parameter int unsigned NIBBLES     = WIDTH / 4,
    parameter int unsigned APPROX_BITS = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    asm_b_precomp_pipe_if.slave  bus
);
    localparam int unsigned      SW       = slot_width(WIDTH, EXT);
    localparam int unsigned      NIB_W    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [NIB_W-1:0] LAST_IDX = NIB_W'(NIBBLES - 1);

    logic                    r_s1_valid;
    logic                    r_s1_approx;
    logic [EXT*SW-1:0]       r_s1_sh;
    logic                    r_m_valid;
    logic [ALPHABETS*SW-1:0] r_mult;
    logic [NIB_W-1:0]        r_nib;

    logic [EXT*SW-1:0]       w_sh;
    logic [ALPHABETS*SW-1:0] w_mults;
    logic                    w_last;
    logic                    w_s2_free;
    logic                    w_s1_adv;
    logic                    w_b_ready;
    logic                    w_b_fire;
    logic                    w_m_fire;

    always_comb begin
        w_sh = '0;
        for (int unsigned s = 0; s < EXT; s++) begin
            w_sh[s*SW +: SW] = SW'(bus.B) << s;
        end
    end

    for (genvar j = 0; j < ALPHABETS; j++) begin : g_odd
        asm_odd_multiple_gen #(
            .WIDTH       (WIDTH),
            .EXT         (EXT),
            .K           (2 * j + 1),
            .APPROX_BITS (APPROX_BITS)
        ) u_gen (
            .i_shifted (r_s1_sh),
            .i_approx  (r_s1_approx),
            .o_mult    (w_mults[slot_offset(j, SW) +: SW])
        );
    end

    // S2 frees up on the retiring beat, so a waiting S1 set loads without a bubble.
    assign w_last    = (r_nib == LAST_IDX);
    assign w_s2_free = !r_m_valid || (bus.m_ready && w_last);
    assign w_s1_adv  = r_s1_valid && w_s2_free;
    assign w_b_ready = !r_s1_valid || w_s2_free;
    assign w_b_fire  = bus.b_valid && w_b_ready;
    assign w_m_fire  = r_m_valid && bus.m_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_approx <= 1'b0;
            r_s1_sh     <= '0;
            r_m_valid   <= 1'b0;
            r_mult      <= '0;
            r_nib       <= '0;
        end else begin
            if (w_b_fire) begin
                r_s1_valid  <= 1'b1;
                r_s1_approx <= bus.approx_en;
                r_s1_sh     <= w_sh;
            end else if (w_s1_adv) begin
                r_s1_valid  <= 1'b0;
            end

            if (w_s1_adv) begin
                r_m_valid <= 1'b1;
                r_mult    <= w_mults;
            end else if (w_m_fire && w_last) begin
                r_m_valid <= 1'b0;
            end

            if (w_m_fire) begin
                r_nib <= w_last ? '0 : r_nib + 1'b1;
            end
        end
    end

    assign bus.b_ready = w_b_ready;
    assign bus.m_valid = r_m_valid;
    assign bus.mult    = r_mult;
    assign bus.nib_idx = r_nib;
    assign bus.last    = w_last;

endmodule
